// File: rtl/freq_counter_pkg.sv
// Shared definitions for the frequency counter and its serial period loader.
package freq_counter_pkg;

  localparam int unsigned DEFAULT_BITS   = 12;
  localparam int unsigned DEFAULT_PERIOD = 1199;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2,
    COMMIT    = 2'd3
  } load_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous pin; both stages reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/period_serial_loader.sv
// Receives a period value over a 3-wire serial link, validates the frame and
// presents it with a one-cycle load strobe (or an error strobe on rejection).
module period_serial_loader
  import freq_counter_pkg::*;
#(
  parameter int unsigned BITS         = DEFAULT_BITS,
  parameter int unsigned RESET_PERIOD = DEFAULT_PERIOD,
  parameter int unsigned MIN_PERIOD   = 10
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            sck,
  input  logic            cs_n,
  input  logic            mosi,
  output logic [BITS-1:0] period,
  output logic            period_load,
  output logic            frame_error,
  output logic            busy
);

  localparam int unsigned     CNT_W    = $clog2(BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(BITS + 1);
  localparam logic [BITS-1:0]  RST_VAL  = BITS'(RESET_PERIOD);
  localparam logic [BITS-1:0]  MIN_VAL  = BITS'(MIN_PERIOD);

  logic sck_sync;
  logic cs_sync;
  logic mosi_sync;

  sync_2ff u_sync_sck  (.clk(clk), .reset_n(reset_n), .d(sck),  .q(sck_sync));
  sync_2ff u_sync_cs   (.clk(clk), .reset_n(reset_n), .d(cs_n), .q(cs_sync));
  sync_2ff u_sync_mosi (.clk(clk), .reset_n(reset_n), .d(mosi), .q(mosi_sync));

  logic        sck_dly_q;
  logic        cs_dly_q;
  load_state_e state_q,   state_d;
  logic [BITS-1:0]  shift_q,  shift_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [BITS-1:0]  period_q, period_d;
  logic        load_q,    load_d;
  logic        err_q,     err_d;
  logic        busy_q,    busy_d;

  logic sck_rise;
  logic cs_fall;
  logic cs_rise;

  assign sck_rise = sck_sync & ~sck_dly_q;
  assign cs_fall  = ~cs_sync & cs_dly_q;
  assign cs_rise  = cs_sync & ~cs_dly_q;

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    load_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      WAIT_IDLE: begin
        if (cs_sync) state_d = IDLE;
      end
      IDLE: begin
        if (cs_fall) begin
          shift_d = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // cs_rise takes priority, so a coincident sck edge is dropped
        if (cs_rise) begin
          state_d = COMMIT;
        end else if (sck_rise && !cs_sync) begin
          shift_d = {shift_q[BITS-2:0], mosi_sync};
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      COMMIT: begin
        state_d = IDLE;
        if (cnt_q == CNT_FULL && shift_q >= MIN_VAL) begin
          period_d = shift_q;
          load_d   = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
    busy_d = (state_d == SHIFT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_dly_q <= 1'b0;
      cs_dly_q  <= 1'b0;
      state_q   <= WAIT_IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      period_q  <= RST_VAL;
      load_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      sck_dly_q <= sck_sync;
      cs_dly_q  <= cs_sync;
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      load_q    <= load_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign period      = period_q;
  assign period_load = load_q;
  assign frame_error = err_q;
  assign busy        = busy_q;

endmodule
